ofdm_s2p_sched: RTL and testbench

- Schedules serial bit ingest into OFDM symbols for the modem transmit path.
- Accepts a serial bit stream with a valid/ready handshake and packs it into subcarrier words (BPS bits per subcarrier, NSC subcarriers per symbol).
- Holds packed symbols in ping-pong banks so the input keeps streaming while the IFFT stage consumes the previous symbol.
- Handles end-of-frame padding and symbol counting for downstream framing.

---
 rtl/ofdm_s2p_sched.sv | 104 ++++++++++
 tb/tb_ofdm_s2p_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_s2p_sched.sv
// Serial-to-parallel symbol packer for the OFDM transmit path.
// Ping-pong banks let ingest continue while the IFFT stage drains the previous symbol.
module ofdm_s2p_sched #(
   parameter int unsigned BPS = 2,
   parameter int unsigned NSC = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_bit,
   input  logic               i_valid,
   input  logic               i_last,
   output logic               o_in_ready,
   output logic [BPS*NSC-1:0] o_sym,
   output logic               o_valid,
   output logic               o_last,
   output logic [15:0]        o_sym_cnt,
   input  logic               i_ready
);

   localparam int unsigned W  = BPS * NSC;
   localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] StEmpty   = 2'd0;
   localparam logic [1:0] StFilling = 2'd1;
   localparam logic [1:0] StFull    = 2'd2;

   logic [W-1:0]  bank_q   [2];
   logic [W-1:0]  bank_d   [2];
   logic [1:0]    status_q [2];
   logic [1:0]    status_d [2];
   logic          last_q   [2];
   logic          last_d   [2];
   logic          wr_sel_q, wr_sel_d;
   logic          rd_sel_q, rd_sel_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [15:0]   cnt_q, cnt_d;

   logic accept, release_rd, complete;

   assign o_in_ready = (status_q[wr_sel_q] != StFull);
   assign o_valid    = (status_q[rd_sel_q] == StFull);
   assign o_sym      = bank_q[rd_sel_q];
   assign o_last     = last_q[rd_sel_q];
   assign o_sym_cnt  = cnt_q;

   assign accept     = i_valid & o_in_ready;
   assign release_rd = o_valid & i_ready;
   assign complete   = (idx_q == IW'(W - 1)) | i_last;

   always_comb begin
      bank_d   = bank_q;
      status_d = status_q;
      last_d   = last_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;

      // Release and accept always target different banks: accept needs a non-FULL
      // write bank, release needs a FULL read bank.
      if (release_rd) begin
         bank_d[rd_sel_q]   = '0;
         status_d[rd_sel_q] = StEmpty;
         last_d[rd_sel_q]   = 1'b0;
         rd_sel_d           = ~rd_sel_q;
         cnt_d              = last_q[rd_sel_q] ? 16'd0 : cnt_q + 16'd1;
      end

      if (accept) begin
         bank_d[wr_sel_q][idx_q] = i_bit;
         if (complete) begin
            // Bits above idx_q were cleared on release, so an early i_last zero-pads.
            status_d[wr_sel_q] = StFull;
            last_d[wr_sel_q]   = i_last;
            idx_d              = '0;
            wr_sel_d           = ~wr_sel_q;
         end else begin
            status_d[wr_sel_q] = StFilling;
            idx_d              = idx_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q   <= '{default: '0};
         status_q <= '{default: StEmpty};
         last_q   <= '{default: 1'b0};
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         idx_q    <= '0;
         cnt_q    <= '0;
      end else begin
         bank_q   <= bank_d;
         status_q <= status_d;
         last_q   <= last_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ofdm_s2p_sched.sv
// Directed and random bench for ofdm_s2p_sched (BPS=2, NSC=4) with an expected-symbol queue.
module tb_ofdm_s2p_sched;

   localparam int BPS = 2;
   localparam int NSC = 4;
   localparam int W   = BPS * NSC;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_bit, i_valid, i_last, i_ready;
   logic          o_in_ready, o_valid, o_last;
   logic [W-1:0]  o_sym;
   logic [15:0]   o_sym_cnt;

   always #5 clk = ~clk;

   ofdm_s2p_sched #(.BPS(BPS), .NSC(NSC)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_bit      (i_bit),
      .i_valid    (i_valid),
      .i_last     (i_last),
      .o_in_ready (o_in_ready),
      .o_sym      (o_sym),
      .o_valid    (o_valid),
      .o_last     (o_last),
      .o_sym_cnt  (o_sym_cnt),
      .i_ready    (i_ready)
   );

   typedef struct packed {
      logic [W-1:0] sym;
      logic         last;
      logic [15:0]  cnt;
   } exp_t;

   exp_t         sb[$];
   int           tests = 0;
   int           fails = 0;
   logic [W-1:0] m_sym;
   int           m_idx;
   logic [15:0]  m_cnt;
   logic         hold_v;
   logic [W-1:0] hold_sym;
   logic         hold_last;
   logic [15:0]  hold_cnt;
   logic         s_ov, s_ir, acc;
   logic         data [24];
   int           ptr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // One clock: drive after the rising edge, sample and score on the falling edge.
   task automatic step(input logic b, input logic v, input logic l, input logic r);
      exp_t e;
      @(posedge clk);
      #1;
      i_bit = b; i_valid = v; i_last = l; i_ready = r;
      @(negedge clk);
      s_ov = o_valid;
      s_ir = o_in_ready;
      acc  = v & o_in_ready;
      if (hold_v) begin
         chk("stall_valid", {31'd0, o_valid}, 32'd1);
         chk("stall_sym", {24'd0, o_sym}, {24'd0, hold_sym});
         chk("stall_last", {31'd0, o_last}, {31'd0, hold_last});
         chk("stall_cnt", {16'd0, o_sym_cnt}, {16'd0, hold_cnt});
      end
      hold_v    = o_valid & ~r;
      hold_sym  = o_sym;
      hold_last = o_last;
      hold_cnt  = o_sym_cnt;
      if (o_valid && r) begin
         chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_sym", {24'd0, o_sym}, {24'd0, e.sym});
            chk("out_last", {31'd0, o_last}, {31'd0, e.last});
            chk("out_cnt", {16'd0, o_sym_cnt}, {16'd0, e.cnt});
         end
      end
      if (acc) begin
         m_sym[m_idx] = b;
         if (m_idx == W - 1 || l) begin
            sb.push_back({m_sym, l, m_cnt});
            m_cnt = l ? 16'd0 : m_cnt + 16'd1;
            m_sym = '0;
            m_idx = 0;
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_valid = 1'b0; i_last = 1'b0; i_bit = 1'b0; i_ready = 1'b0;
      #1;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
      chk("rst_sym", {24'd0, o_sym}, 32'd0);
      chk("rst_last", {31'd0, o_last}, 32'd0);
      chk("rst_cnt", {16'd0, o_sym_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_sym = '0; m_idx = 0; m_cnt = '0; hold_v = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk({tag, "_sb_empty"}, sb.size(), 32'd0);
      chk({tag, "_idle"}, {31'd0, s_ov}, 32'd0);
   endtask

   initial begin
      logic [7:0] t1;
      rst = 1'b0;
      #2;
      do_reset();

      // Basic packing and completion latency.
      t1 = 8'b0100_1101;
      for (int i = 0; i < W; i++) step(t1[i], 1'b1, 1'b0, 1'b1);
      chk("lat_before", {31'd0, s_ov}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("lat_valid", {31'd0, s_ov}, 32'd1);
      drain("basic");

      // Back-pressure: both banks fill, then drain in order.
      do_reset();
      for (int i = 0; i < 24; i++) data[i] = 1'($urandom_range(0, 1));
      ptr = 0;
      for (int i = 0; i < 20; i++) begin
         step(data[ptr], 1'b1, 1'b0, 1'b0);
         if (acc) ptr++;
      end
      chk("stall_accepted", ptr, 32'd16);
      chk("stall_in_ready", {31'd0, s_ir}, 32'd0);
      step(data[ptr], 1'b1, 1'b0, 1'b1);
      chk("stall_rel_acc", {31'd0, acc}, 32'd0);
      if (acc) ptr++;
      step(data[ptr], 1'b1, 1'b0, 1'b1);
      chk("stall_resume_acc", {31'd0, acc}, 32'd1);
      if (acc) ptr++;
      for (int i = 0; i < 50 && ptr < 24; i++) begin
         step(data[ptr], 1'b1, 1'b0, 1'b1);
         if (acc) ptr++;
      end
      chk("stall_all_in", ptr, 32'd24);
      drain("stall");

      // Padded final symbol, then a new frame restarts the count.
      do_reset();
      for (int i = 0; i < 11; i++) step(1'b1, 1'b1, (i == 10), 1'b1);
      for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      drain("pad");

      // i_last exactly on the final bit: no extra symbol.
      do_reset();
      for (int i = 0; i < W; i++) step(1'(i & 1), 1'b1, (i == W - 1), 1'b1);
      drain("exact");

      // i_last on the first bit of a symbol.
      for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      drain("one_bit");

      // Random stream with random valid and back-pressure.
      do_reset();
      ptr = 0;
      for (int i = 0; i < 5000 && ptr < 1000; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)));
         if (acc) ptr++;
      end
      chk("rand_all_in", ptr, 32'd1000);
      drain("rand");

      // Asynchronous reset with both banks full.
      for (int i = 0; i < 2 * W + 2; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
      chk("pre_rst_in_ready", {31'd0, o_in_ready}, 32'd0);
      #2;
      do_reset();

      // Asynchronous reset mid-fill, then only post-reset bits appear.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      #2;
      do_reset();
      t1 = 8'b1010_0110;
      for (int i = 0; i < W; i++) step(t1[i], 1'b1, 1'b0, 1'b1);
      drain("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
